// File: rtl/count_arb_pkg.sv
// Shared state encoding and burst-length helper for the count arbiter slice.
package count_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int BW_MAX = 8;

    // A zero length encodes the full 2**bw burst, so the result needs one extra bit.
    function automatic logic [BW_MAX:0] burst_len(input logic [BW_MAX-1:0] len, input int bw);
        logic [BW_MAX:0] r;
        r = {1'b0, len};
        if (len == '0) r = (BW_MAX+1)'(1) << bw;
        return r;
    endfunction

endpackage

// File: rtl/count_arbiter_if.sv
// Requester-side bus of the count arbiter; lock exists only with COUNT_ARB_LOCK_EN.
interface count_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int BW     = 4,
    parameter int STEP_W = 1
);
    logic [NREQ-1:0]        req;
    logic [NREQ*BW-1:0]     req_len;
    logic [NREQ*STEP_W-1:0] req_step;
    logic [NREQ-1:0]        req_clr;
`ifdef COUNT_ARB_LOCK_EN
    logic                   lock;
`endif
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [STEP_W-1:0]      cnt_step;
    logic [NREQ-1:0]        done;
    logic                   abort;

`ifdef COUNT_ARB_LOCK_EN
    modport master (output req, req_len, req_step, req_clr, lock,
                    input  grant, busy, cnt_clr, cnt_en, cnt_step, done, abort);
    modport slave  (input  req, req_len, req_step, req_clr, lock,
                    output grant, busy, cnt_clr, cnt_en, cnt_step, done, abort);
`else
    modport master (output req, req_len, req_step, req_clr,
                    input  grant, busy, cnt_clr, cnt_en, cnt_step, done, abort);
    modport slave  (input  req, req_len, req_step, req_clr,
                    output grant, busy, cnt_clr, cnt_en, cnt_step, done, abort);
`endif

endinterface

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin owner of the shared step counter. With COUNT_ARB_LOCK_EN defined,
// lock held during DONE keeps arbitration starting from the current owner.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int BW     = 4,
    parameter int STEP_W = 1
) (
    input  logic           clock,
    input  logic           reset,
    count_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    state_t            state;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic              abort_q;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [BW:0]       remaining;

    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic [BW_MAX-1:0] len_ext;
    logic [BW_MAX:0]   len_full;
    logic              owner_req;
    logic [STEP_W-1:0] owner_step;
    logic [PW-1:0]     next_ptr;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        len_ext         = '0;
        len_ext[BW-1:0] = bus.req_len[int'(pick_idx)*BW +: BW];
    end

    assign len_full   = burst_len(len_ext, BW);
    assign owner_req  = bus.req[owner];
    assign owner_step = bus.req_step[int'(owner)*STEP_W +: STEP_W];
    assign next_ptr   = (int'(owner) == NREQ-1) ? '0 : owner + PW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            abort_q   <= 1'b0;
            ptr       <= '0;
            owner     <= '0;
            remaining <= '0;
        end else begin
            done_q <= '0;
            case (state)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (|bus.req) begin
                        grant_q   <= pick_onehot;
                        owner     <= pick_idx;
                        remaining <= len_full[BW:0];
                        state     <= bus.req_clr[pick_idx] ? S_CLR : S_RUN;
                    end
                end
                S_CLR: begin
                    if (!owner_req) begin
                        abort_q <= 1'b1;
                        grant_q <= '0;
                        done_q  <= grant_q;
                        state   <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // An owner dropping its request ends the burst without stepping.
                    if (!owner_req) begin
                        abort_q <= 1'b1;
                        grant_q <= '0;
                        done_q  <= grant_q;
                        state   <= S_DONE;
                    end else begin
                        remaining <= remaining - (BW+1)'(1);
                        if (remaining == (BW+1)'(1)) begin
                            grant_q <= '0;
                            done_q  <= grant_q;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    abort_q <= 1'b0;
                    state   <= S_IDLE;
`ifdef COUNT_ARB_LOCK_EN
                    ptr     <= bus.lock ? owner : next_ptr;
`else
                    ptr     <= next_ptr;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.cnt_clr  = (state == S_CLR);
    assign bus.cnt_en   = (state == S_RUN) && owner_req;
    assign bus.cnt_step = (state == S_RUN) ? owner_step : '0;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;

endmodule
